// File: rtl/wb_compressor_if.sv
// Bundles the Wishbone slave port and the compressed-wishbone pin bus
// of the ppcpu-side initiator into one interface.
//
// Handshake: a Wishbone request is valid when wb_cyc & wb_stb are both high;
// the slave answers with exactly one cycle of wb_ack or wb_err. On the cw
// side, cw_dir=1 means the initiator drives cw_io_o, cw_req marks the first
// beat, and the responder answers with cw_ack (read data valid on cw_io_i
// the same cycle) or cw_err while cw_dir=0.
interface wb_compressor_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [23:0] wb_adr;
    logic [1:0]  wb_sel;
    logic [15:0] wb_i_dat;
    logic [15:0] wb_o_dat;
    logic        wb_ack;
    logic        wb_err;
    logic [15:0] cw_io_o;
    logic [15:0] cw_io_i;
    logic        cw_req;
    logic        cw_dir;
    logic        cw_ack;
    logic        cw_err;

    // View of the compressor: Wishbone slave, cw initiator.
    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_i_dat,
        output wb_o_dat, wb_ack, wb_err,
        output cw_io_o, cw_req, cw_dir,
        input  cw_io_i, cw_ack, cw_err
    );

    // View of the surroundings: Wishbone master plus cw responder.
    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_i_dat,
        input  wb_o_dat, wb_ack, wb_err,
        input  cw_io_o, cw_req, cw_dir,
        output cw_io_i, cw_ack, cw_err
    );
endinterface

// File: rtl/wb_compressor.sv
// wb_compressor: serialises one classic Wishbone cycle into 16-bit beats on
// the cw pin bus (address low, {we,sel,adr high}, optional write data), then
// turns the bus around and waits for cw_ack/cw_err with a bounded timeout.
// All outputs come straight from registers.
module wb_compressor #(
    parameter int TO_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    wb_compressor_if.slave        bus,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADR0 = 3'd1,
        S_ADR1 = 3'd2,
        S_DATA = 3'd3,
        S_WAIT = 3'd4,
        S_RESP = 3'd5
    } state_t;

    // Counter value whose increment reaches all-ones: the last WAIT cycle.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [23:0]     adr_q, adr_d;
    logic [1:0]      sel_q, sel_d;
    logic [15:0]     wdat_q, wdat_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [15:0]     rdat_q, rdat_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            req_q, req_d;
    logic            dir_q, dir_d;
    logic [15:0]     io_q, io_d;

    // State, latched request and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            wdat_q  <= '0;
            cnt_q   <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            dir_q   <= 1'b1;
            io_q    <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            cnt_q   <= cnt_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            req_q   <= req_d;
            dir_q   <= dir_d;
            io_q    <= io_d;
        end
    end

    // Next state, request latching, and output values for the state being entered.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        cnt_d   = cnt_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        req_d   = 1'b0;
        dir_d   = 1'b1;
        io_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.wb_cyc && bus.wb_stb) begin
                    we_d    = bus.wb_we;
                    adr_d   = bus.wb_adr;
                    sel_d   = bus.wb_sel;
                    wdat_d  = bus.wb_i_dat;
                    state_d = S_ADR0;
                end
            end
            S_ADR0: state_d = S_ADR1;
            S_ADR1: state_d = we_q ? S_DATA : S_WAIT;
            S_DATA: state_d = S_WAIT;
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // err beats ack, ack beats the timeout; a dropped wb_cyc only
                // suppresses the Wishbone response, not the cw sequence.
                if (bus.cw_err) begin
                    err_d   = bus.wb_cyc;
                    state_d = S_RESP;
                end else if (bus.cw_ack) begin
                    if (!we_q) begin
                        rdat_d = bus.cw_io_i;
                    end
                    ack_d   = bus.wb_cyc;
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = bus.wb_cyc;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_ADR0: begin
                req_d = 1'b1;
                io_d  = adr_d[15:0];
            end
            S_ADR1: io_d = {we_q, sel_q, 5'b0, adr_q[23:16]};
            S_DATA: io_d = wdat_q;
            S_WAIT: dir_d = 1'b0;
            default: ;
        endcase
    end

    assign bus.wb_o_dat = rdat_q;
    assign bus.wb_ack   = ack_q;
    assign bus.wb_err   = err_q;
    assign bus.cw_req   = req_q;
    assign bus.cw_dir   = dir_q;
    assign bus.cw_io_o  = io_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_wb_compressor.sv
// Directed bench for wb_compressor with TO_W=4: read, write with responder
// wait states, responder error, timeout, ack/err collision, dropped wb_cyc,
// reset during WAIT and back-to-back requests.
module tb_wb_compressor;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd4;
    localparam logic [2:0] ST_RESP = 3'd5;

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;
    int         vec_cnt;
    int         err_cnt;
    logic [15:0] exp_q[$];
    logic [15:0] exp_beat;

    wb_compressor_if bus ();

    wb_compressor #(.TO_W(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle past the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [23:0] adr,
                             input logic [1:0] sel, input logic [15:0] dat);
        bus.wb_cyc   = 1'b1;
        bus.wb_stb   = 1'b1;
        bus.wb_we    = we;
        bus.wb_adr   = adr;
        bus.wb_sel   = sel;
        bus.wb_i_dat = dat;
    endtask

    task automatic end_req();
        bus.wb_cyc = 1'b0;
        bus.wb_stb = 1'b0;
    endtask

    task automatic respond(input logic ack, input logic err, input logic [15:0] dat);
        bus.cw_ack  = ack;
        bus.cw_err  = err;
        bus.cw_io_i = dat;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        vec_cnt++; if (bus.cw_req !== 1'b0) begin err_cnt++; $display("FAIL rst_req got %0b exp 0", bus.cw_req); end
        vec_cnt++; if (bus.cw_dir !== 1'b1) begin err_cnt++; $display("FAIL rst_dir got %0b exp 1", bus.cw_dir); end
        vec_cnt++; if (bus.cw_io_o !== 16'h0000) begin err_cnt++; $display("FAIL rst_io got %h exp 0000", bus.cw_io_o); end
        vec_cnt++; if (bus.wb_ack !== 1'b0 || bus.wb_err !== 1'b0) begin err_cnt++; $display("FAIL rst_resp got ack=%0b err=%0b exp 0/0", bus.wb_ack, bus.wb_err); end
        vec_cnt++; if (bus.wb_o_dat !== 16'h0000) begin err_cnt++; $display("FAIL rst_odat got %h exp 0000", bus.wb_o_dat); end
        vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL rst_state got %0d exp %0d", dbg_state, ST_IDLE); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read();
        exp_q.push_back(16'hE004);
        exp_q.push_back(16'h60FF);
        start_req(1'b0, 24'hFFE004, 2'b11, 16'h0000);
        tick(); // cycle 1: ADR0
        exp_beat = exp_q.pop_front();
        vec_cnt++; if (bus.cw_io_o !== exp_beat || bus.cw_req !== 1'b1) begin err_cnt++; $display("FAIL rd_beat0 got %h req=%0b exp %h req=1", bus.cw_io_o, bus.cw_req, exp_beat); end
        tick(); // cycle 2: ADR1
        exp_beat = exp_q.pop_front();
        vec_cnt++; if (bus.cw_io_o !== exp_beat || bus.cw_req !== 1'b0) begin err_cnt++; $display("FAIL rd_beat1 got %h req=%0b exp %h req=0", bus.cw_io_o, bus.cw_req, exp_beat); end
        tick(); // cycle 3: WAIT
        vec_cnt++; if (bus.cw_dir !== 1'b0) begin err_cnt++; $display("FAIL rd_dir got %0b exp 0", bus.cw_dir); end
        respond(1'b1, 1'b0, 16'hBEEF);
        tick(); // cycle 4: RESP
        respond(1'b0, 1'b0, 16'h0000);
        vec_cnt++; if (bus.wb_ack !== 1'b1 || bus.wb_err !== 1'b0) begin err_cnt++; $display("FAIL rd_ack got ack=%0b err=%0b exp 1/0", bus.wb_ack, bus.wb_err); end
        vec_cnt++; if (bus.wb_o_dat !== 16'hBEEF) begin err_cnt++; $display("FAIL rd_data got %h exp beef", bus.wb_o_dat); end
        end_req();
        tick(); // cycle 5: IDLE
        vec_cnt++; if (bus.wb_ack !== 1'b0 || dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL rd_done got ack=%0b state=%0d exp 0/%0d", bus.wb_ack, dbg_state, ST_IDLE); end
    endtask

    task automatic test_write_wait();
        exp_q.push_back(16'h0010);
        exp_q.push_back(16'hA010);
        exp_q.push_back(16'h1234);
        start_req(1'b1, 24'h100010, 2'b01, 16'h1234);
        tick(); // cycle 1: ADR0
        // Scramble the request inputs: the latched copy must be used.
        bus.wb_we = 1'b0; bus.wb_adr = 24'h0; bus.wb_sel = 2'b00; bus.wb_i_dat = 16'h0;
        exp_beat = exp_q.pop_front();
        vec_cnt++; if (bus.cw_io_o !== exp_beat || bus.cw_req !== 1'b1) begin err_cnt++; $display("FAIL wr_beat0 got %h req=%0b exp %h req=1", bus.cw_io_o, bus.cw_req, exp_beat); end
        tick(); // cycle 2: ADR1
        exp_beat = exp_q.pop_front();
        vec_cnt++; if (bus.cw_io_o !== exp_beat) begin err_cnt++; $display("FAIL wr_beat1 got %h exp %h", bus.cw_io_o, exp_beat); end
        tick(); // cycle 3: DATA
        exp_beat = exp_q.pop_front();
        vec_cnt++; if (bus.cw_io_o !== exp_beat || bus.cw_dir !== 1'b1) begin err_cnt++; $display("FAIL wr_beat2 got %h dir=%0b exp %h dir=1", bus.cw_io_o, bus.cw_dir, exp_beat); end
        for (int i = 0; i < 3; i++) begin
            tick(); // cycles 4..6: WAIT, no response
            vec_cnt++; if (bus.cw_dir !== 1'b0 || bus.wb_ack !== 1'b0) begin err_cnt++; $display("FAIL wr_wait%0d got dir=%0b ack=%0b exp 0/0", i, bus.cw_dir, bus.wb_ack); end
        end
        tick(); // cycle 7: WAIT, responder acks
        respond(1'b1, 1'b0, 16'h5555);
        tick(); // cycle 8: RESP
        respond(1'b0, 1'b0, 16'h0000);
        vec_cnt++; if (bus.wb_ack !== 1'b1) begin err_cnt++; $display("FAIL wr_ack got %0b exp 1", bus.wb_ack); end
        vec_cnt++; if (bus.wb_o_dat !== 16'hBEEF) begin err_cnt++; $display("FAIL wr_odat got %h exp beef", bus.wb_o_dat); end
        end_req();
        tick();
    endtask

    task automatic test_resp_err();
        start_req(1'b0, 24'h000050, 2'b11, 16'h0000);
        tick();
        vec_cnt++; if (bus.cw_io_o !== 16'h0050) begin err_cnt++; $display("FAIL er_beat0 got %h exp 0050", bus.cw_io_o); end
        tick();
        vec_cnt++; if (bus.cw_io_o !== 16'h6000) begin err_cnt++; $display("FAIL er_beat1 got %h exp 6000", bus.cw_io_o); end
        tick(); // WAIT
        respond(1'b0, 1'b1, 16'hDEAD);
        tick(); // RESP
        respond(1'b0, 1'b0, 16'h0000);
        vec_cnt++; if (bus.wb_err !== 1'b1 || bus.wb_ack !== 1'b0) begin err_cnt++; $display("FAIL er_resp got ack=%0b err=%0b exp 0/1", bus.wb_ack, bus.wb_err); end
        vec_cnt++; if (bus.wb_o_dat !== 16'hBEEF) begin err_cnt++; $display("FAIL er_odat got %h exp beef", bus.wb_o_dat); end
        end_req();
        tick();
        vec_cnt++; if (bus.wb_err !== 1'b0) begin err_cnt++; $display("FAIL er_len got %0b exp 0", bus.wb_err); end
    endtask

    task automatic test_timeout();
        start_req(1'b0, 24'h000123, 2'b10, 16'h0000);
        tick();
        tick();
        for (int i = 0; i < 15; i++) begin
            tick(); // WAIT cycles 1..15
            vec_cnt++; if (bus.wb_err !== 1'b0 || dbg_state !== ST_WAIT) begin err_cnt++; $display("FAIL to_wait%0d got err=%0b state=%0d exp 0/%0d", i, bus.wb_err, dbg_state, ST_WAIT); end
        end
        tick(); // RESP
        vec_cnt++; if (bus.wb_err !== 1'b1 || bus.wb_ack !== 1'b0) begin err_cnt++; $display("FAIL to_err got ack=%0b err=%0b exp 0/1", bus.wb_ack, bus.wb_err); end
        end_req();
        tick();
        vec_cnt++; if (dbg_state !== ST_IDLE || bus.wb_err !== 1'b0) begin err_cnt++; $display("FAIL to_idle got state=%0d err=%0b exp %0d/0", dbg_state, bus.wb_err, ST_IDLE); end
        // Follow-up read must complete normally.
        start_req(1'b0, 24'h000124, 2'b11, 16'h0000);
        tick();
        tick();
        tick();
        respond(1'b1, 1'b0, 16'h0A0A);
        tick();
        respond(1'b0, 1'b0, 16'h0000);
        vec_cnt++; if (bus.wb_ack !== 1'b1 || bus.wb_o_dat !== 16'h0A0A) begin err_cnt++; $display("FAIL to_next got ack=%0b dat=%h exp 1/0a0a", bus.wb_ack, bus.wb_o_dat); end
        end_req();
        tick();
    endtask

    task automatic test_ack_err_same();
        start_req(1'b0, 24'h000200, 2'b11, 16'h0000);
        tick();
        tick();
        tick();
        respond(1'b1, 1'b1, 16'h7777);
        tick();
        respond(1'b0, 1'b0, 16'h0000);
        vec_cnt++; if (bus.wb_err !== 1'b1 || bus.wb_ack !== 1'b0) begin err_cnt++; $display("FAIL both_resp got ack=%0b err=%0b exp 0/1", bus.wb_ack, bus.wb_err); end
        vec_cnt++; if (bus.wb_o_dat !== 16'h0A0A) begin err_cnt++; $display("FAIL both_odat got %h exp 0a0a", bus.wb_o_dat); end
        end_req();
        tick();
    endtask

    task automatic test_cyc_drop();
        start_req(1'b0, 24'h000300, 2'b11, 16'h0000);
        tick(); // ADR0
        tick(); // ADR1
        end_req();
        tick(); // WAIT
        vec_cnt++; if (bus.cw_dir !== 1'b0 || dbg_state !== ST_WAIT) begin err_cnt++; $display("FAIL drop_wait got dir=%0b state=%0d exp 0/%0d", bus.cw_dir, dbg_state, ST_WAIT); end
        respond(1'b1, 1'b0, 16'h1111);
        tick(); // RESP, silent
        respond(1'b0, 1'b0, 16'h0000);
        vec_cnt++; if (bus.wb_ack !== 1'b0 || bus.wb_err !== 1'b0 || dbg_state !== ST_RESP) begin err_cnt++; $display("FAIL drop_resp got ack=%0b err=%0b state=%0d exp 0/0/%0d", bus.wb_ack, bus.wb_err, dbg_state, ST_RESP); end
        tick();
        vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL drop_idle got %0d exp %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_reset_in_wait();
        start_req(1'b0, 24'h000400, 2'b11, 16'h0000);
        tick();
        tick();
        tick(); // WAIT
        rst = 1'b0;
        tick();
        rst = 1'b1;
        vec_cnt++; if (bus.cw_dir !== 1'b1 || bus.cw_req !== 1'b0 || bus.cw_io_o !== 16'h0000) begin err_cnt++; $display("FAIL rw_cw got dir=%0b req=%0b io=%h exp 1/0/0000", bus.cw_dir, bus.cw_req, bus.cw_io_o); end
        vec_cnt++; if (bus.wb_ack !== 1'b0 || bus.wb_err !== 1'b0 || bus.wb_o_dat !== 16'h0000) begin err_cnt++; $display("FAIL rw_wb got ack=%0b err=%0b dat=%h exp 0/0/0000", bus.wb_ack, bus.wb_err, bus.wb_o_dat); end
        vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL rw_state got %0d exp %0d", dbg_state, ST_IDLE); end
        end_req();
        respond(1'b1, 1'b0, 16'h9999); // late ack, must be ignored
        tick();
        respond(1'b0, 1'b0, 16'h0000);
        vec_cnt++; if (bus.wb_ack !== 1'b0 || dbg_state !== ST_IDLE || bus.wb_o_dat !== 16'h0000) begin err_cnt++; $display("FAIL rw_late got ack=%0b state=%0d dat=%h exp 0/%0d/0000", bus.wb_ack, dbg_state, bus.wb_o_dat, ST_IDLE); end
    endtask

    task automatic test_back_to_back();
        start_req(1'b1, 24'h0000AA, 2'b11, 16'hCAFE);
        tick(); // ADR0
        tick(); // ADR1
        tick(); // DATA
        tick(); // WAIT
        respond(1'b1, 1'b0, 16'h0000);
        tick(); // RESP (cycle 5)
        respond(1'b0, 1'b0, 16'h0000);
        vec_cnt++; if (bus.wb_ack !== 1'b1) begin err_cnt++; $display("FAIL b2b_wack got %0b exp 1", bus.wb_ack); end
        end_req();
        tick(); // IDLE
        vec_cnt++; if (bus.cw_req !== 1'b0 || dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL b2b_gap got req=%0b state=%0d exp 0/%0d", bus.cw_req, dbg_state, ST_IDLE); end
        start_req(1'b0, 24'h3456AB, 2'b10, 16'h0000);
        tick(); // ADR0, two cycles after RESP
        vec_cnt++; if (bus.cw_req !== 1'b1 || bus.cw_io_o !== 16'h56AB) begin err_cnt++; $display("FAIL b2b_adr0 got req=%0b io=%h exp 1/56ab", bus.cw_req, bus.cw_io_o); end
        tick();
        vec_cnt++; if (bus.cw_io_o !== 16'h4034) begin err_cnt++; $display("FAIL b2b_adr1 got %h exp 4034", bus.cw_io_o); end
        tick();
        respond(1'b1, 1'b0, 16'h3C3C);
        tick();
        respond(1'b0, 1'b0, 16'h0000);
        vec_cnt++; if (bus.wb_ack !== 1'b1 || bus.wb_o_dat !== 16'h3C3C) begin err_cnt++; $display("FAIL b2b_rd got ack=%0b dat=%h exp 1/3c3c", bus.wb_ack, bus.wb_o_dat); end
        end_req();
        tick();
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b0;
        end_req();
        bus.wb_we = 1'b0;
        bus.wb_adr = '0;
        bus.wb_sel = '0;
        bus.wb_i_dat = '0;
        respond(1'b0, 1'b0, 16'h0000);
        #1;
        test_reset();
        test_read();
        test_write_wait();
        test_resp_err();
        test_timeout();
        test_ack_err_same();
        test_cyc_drop();
        test_reset_in_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/wb_compressor.md
# wb_compressor

Wishbone slave that serialises each classic (non-pipelined) Wishbone cycle from the ppcpu core onto the 16-bit compressed-wishbone (cw) pin bus. It is the initiator end of the cw link and sits inside the core next to the padframe. Off-chip, `wb_decomp` rebuilds the Wishbone cycle and returns ack or err. It also bounds the wait for a response with a timeout.

## Interface
Parameters:
- `TO_W`, default 8: width of the response timeout counter. Timeout fires after 2^TO_W−1 WAIT cycles.

Ports:
- `i_clk  in  1`: single clock for the block; the cw bus runs on the same clock.
- `i_rst  in  1`: synchronous, active-low reset.
- `wb_cyc  in  1`: Wishbone cycle.
- `wb_stb  in  1`: Wishbone strobe.
- `wb_we  in  1`: write enable.
- `wb_adr  in  24`: word address.
- `wb_sel  in  2`: byte selects.
- `wb_i_dat  in  16`: write data from the master.
- `wb_o_dat  out  16`: read data to the master.
- `wb_ack  out  1`: one-cycle acknowledge.
- `wb_err  out  1`: one-cycle error.
- `cw_io_o  out  16`: bus data driven by the initiator.
- `cw_io_i  in  16`: bus data driven by the responder.
- `cw_req  out  1`: first-beat marker.
- `cw_dir  out  1`: bus direction. 1 = initiator drives, 0 = responder drives.
- `cw_ack  in  1`: responder acknowledge; read data is valid on `cw_io_i` in the same cycle.
- `cw_err  in  1`: responder error.

## Operation
All outputs are registered. Reset values: `cw_req`=0, `cw_dir`=1, `cw_io_o`=0, `wb_ack`=0, `wb_err`=0, `wb_o_dat`=0, state=IDLE, timeout counter=0.

State machine:
- **IDLE**
  - Outputs: `cw_dir`=1, `cw_io_o`=0.
  - When `wb_cyc & wb_stb` is sampled: latch `we`, `adr`, `sel` and write data, then go to ADR0.
- **ADR0**
  - Outputs: `cw_req`=1, `cw_dir`=1, `cw_io_o`=`adr[15:0]`.
  - Next state: ADR1.
- **ADR1**
  - Outputs: `cw_req`=0, `cw_dir`=1.
  - `cw_io_o` = {`we`, `sel[1:0]`, 5'b0, `adr[23:16]`}.
  - Next state: DATA if `we`, otherwise WAIT.
- **DATA**
  - Outputs: `cw_dir`=1, `cw_io_o`=write data.
  - Next state: WAIT.
- **WAIT**
  - Outputs: `cw_dir`=0, `cw_io_o`=0. The timeout counter increments every cycle.
  - `cw_err` sampled → go to RESP with err.
  - Else `cw_ack` sampled → capture `cw_io_i` into `wb_o_dat` (reads only; writes leave `wb_o_dat` unchanged) and go to RESP with ack.
  - Else counter reaches all-ones → go to RESP with err.
- **RESP**
  - If `wb_cyc` is still high: `wb_ack` or `wb_err` is high for exactly this cycle.
  - If `wb_cyc` dropped: the response is suppressed.
  - Outputs: `cw_dir`=1. Clear the counter. Next state: IDLE.

Rules:
- `cw_ack` and `cw_err` are ignored outside WAIT.
- Simultaneous `cw_ack` and `cw_err`: err wins, and no data is captured.
- `cw_ack` in the same cycle the counter saturates: ack wins.
- `wb_cyc` dropping mid-transaction does not abort the cw sequence; it runs to RESP, then returns to IDLE silently.
- `wb_adr`, `wb_sel`, `wb_we` and `wb_i_dat` changing after the IDLE sample have no effect (latched values are used).
- Only one transaction is outstanding; no new request is accepted before IDLE.
- Reset asserted in any state: state returns to IDLE with reset values next cycle, with no ack or err. The responder sees `cw_dir` return to 1.

## Timing
- Take the request sampled at edge 0.
- ADR0 occupies cycle 1 and ADR1 cycle 2.
- Read: WAIT starts at cycle 3. If `cw_ack` arrives in the first WAIT cycle, `wb_ack` is high in cycle 4 (minimum read latency 4).
- Write: DATA is cycle 3 and WAIT starts at cycle 4. Minimum `wb_ack` is in cycle 5.
- Each extra responder wait cycle adds one cycle of latency.
- Timeout: with TO_W=8 and no response, `wb_err` appears 255 WAIT cycles after WAIT entry, plus one cycle.
- The master deasserts `wb_stb` on the edge that samples `wb_ack`. IDLE is entered after RESP, so the same strobe is never re-accepted.
- Back-to-back requests: the earliest next ADR0 is 2 cycles after RESP.

## Test plan
- **Read:** `adr`=0xFFE004, `sel`=2'b11, responder acks in the first WAIT cycle with 0xBEEF.
  - Expected: `cw_io_o` is 0xE004 with `cw_req`=1, then 0x60FF.
  - Expected: `wb_o_dat`=0xBEEF with `wb_ack` in cycle 4.
- **Write:** `adr`=0x100010, `sel`=2'b01, data 0x1234, responder acks after 3 wait cycles.
  - Expected: beats 0x0010, 0xA010, 0x1234; `cw_dir`=0 in WAIT.
  - Expected: `wb_ack` in cycle 8; `wb_o_dat` unchanged.
- **Responder err** on a read to 0x000050.
  - Expected: one-cycle `wb_err`, no `wb_ack`, `wb_o_dat` unchanged.
- **Silent responder** with TO_W=4.
  - Expected: `wb_err` in the cycle after 15 WAIT cycles, then IDLE.
  - Expected: the next request completes normally.
- **`cw_ack` and `cw_err` in the same WAIT cycle.**
  - Expected: only `wb_err`.
- **`wb_cyc` dropped during ADR1.**
  - Expected: the sequence completes with no `wb_ack` or `wb_err`.
- **Reset asserted in WAIT.**
  - Expected: all outputs are at reset values next cycle.
  - Expected: a late `cw_ack` is ignored.
